// File: rtl/interp_upsampler.sv
// rtl/interp_upsampler.sv - input FIFO plus zero-stuff / zero-order-hold upsampler with power-of-two gain
//
// Accepts input-rate samples over a valid/ready handshake into a small FIFO.
// It emits one output-rate sample every clock. Each popped sample is followed
// by UPSAMPLE_FACTOR-1 zeros, or by held copies of it when hold_mode is set.
//
// Ports:
//   clk           single clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   in_data       signed input-rate sample
//   in_valid      in_data valid
//   in_ready      FIFO not full; a transfer happens when in_valid && in_ready
//   out           signed output-rate sample (registered)
//   out_strobe    high while out carries a phase-0 slot
//   hold_mode     0 = zero-stuff, 1 = repeat the held value on phases 1..L-1
//   underflow     sticky: a phase-0 slot found the FIFO empty
//   clr_underflow synchronous clear of underflow (a new underflow wins)

module interp_upsampler #(
  parameter int DATA_WIDTH      = 5,
  parameter int UPSAMPLE_FACTOR = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAIN_SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_strobe,
  input  logic                         hold_mode,
  output logic                         underflow,
  input  logic                         clr_underflow
);

  localparam int PW = (UPSAMPLE_FACTOR > 1) ? $clog2(UPSAMPLE_FACTOR) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + GAIN_SHIFT;

  localparam logic [PW-1:0]        P_LAST  = PW'(UPSAMPLE_FACTOR - 1);
  localparam logic [CW-1:0]        C_FULL  = CW'(FIFO_DEPTH);
  localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (DATA_WIDTH - 1)));

  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [CW-1:0]                count;
  logic [PW-1:0]                phase;
  logic signed [DATA_WIDTH-1:0] held;

  logic                         push;
  logic                         pop;
  logic                         slot0;
  logic                         empty;
  logic signed [EW-1:0]         ext;
  logic signed [EW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] scaled;

  // in_ready looks only at the registered count: a pop in the same cycle
  // never frees a slot early, so there is no ready-from-pop path.
  assign in_ready = (count != C_FULL);
  assign empty    = (count == '0);
  assign slot0    = (phase == '0);
  assign push     = in_valid && in_ready;
  assign pop      = slot0 && !empty;

  // Head sample widened so the shift cannot overflow, then clamped back
  // into the signed DATA_WIDTH range.
  always_comb begin
    ext     = EW'(mem[rd_ptr]);
    shifted = ext <<< GAIN_SHIFT;
    if (shifted > SAT_MAX) begin
      scaled = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      scaled = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      scaled = shifted[DATA_WIDTH-1:0];
    end
  end

  // Storage needs no reset: entries are only read after the pointers,
  // which are reset, say they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (phase == P_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= '0;
      out_strobe <= 1'b0;
      held       <= '0;
    end else if (slot0) begin
      out_strobe <= 1'b1;
      if (!empty) begin
        out  <= scaled;
        held <= scaled;
      end else begin
        out  <= '0;
        held <= '0;
      end
    end else begin
      out_strobe <= 1'b0;
      out        <= hold_mode ? held : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (slot0 && empty) begin
      underflow <= 1'b1;
    end else if (clr_underflow) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interp_upsampler.sv
// tb/tb_interp_upsampler.sv - self-checking bench for interp_upsampler

module tb_interp_upsampler;

  localparam int W  = 5;
  localparam int FD = 4;

  logic                clk;
  logic                rst_n;
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                hold_mode;
  logic                clr;

  logic                ready_a, ready_g, ready_1;
  logic signed [W-1:0] out_a, out_g, out_1;
  logic                strobe_a, strobe_g, strobe_1;
  logic                uf_a, uf_g, uf_1;

  // L=4 shift 0, L=4 shift 1, L=1 shift 0; all share the same inputs.
  interp_upsampler #(.DATA_WIDTH(W), .UPSAMPLE_FACTOR(4), .FIFO_DEPTH(FD), .GAIN_SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready_a),
    .out(out_a), .out_strobe(strobe_a), .hold_mode(hold_mode), .underflow(uf_a),
    .clr_underflow(clr)
  );

  interp_upsampler #(.DATA_WIDTH(W), .UPSAMPLE_FACTOR(4), .FIFO_DEPTH(FD), .GAIN_SHIFT(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready_g),
    .out(out_g), .out_strobe(strobe_g), .hold_mode(hold_mode), .underflow(uf_g),
    .clr_underflow(clr)
  );

  interp_upsampler #(.DATA_WIDTH(W), .UPSAMPLE_FACTOR(1), .FIFO_DEPTH(FD), .GAIN_SHIFT(0)) dut_1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ready_1),
    .out(out_1), .out_strobe(strobe_1), .hold_mode(hold_mode), .underflow(uf_1),
    .clr_underflow(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                  sel;
  logic                obs_ready;
  logic signed [W-1:0] obs_out;
  logic                obs_strobe;
  logic                obs_uf;

  always_comb begin
    obs_ready  = ready_a;
    obs_out    = out_a;
    obs_strobe = strobe_a;
    obs_uf     = uf_a;
    if (sel == 1) begin
      obs_ready  = ready_g;
      obs_out    = out_g;
      obs_strobe = strobe_g;
      obs_uf     = uf_g;
    end else if (sel == 2) begin
      obs_ready  = ready_1;
      obs_out    = out_1;
      obs_strobe = strobe_1;
      obs_uf     = uf_1;
    end
  end

  int vectors;
  int miscompares;

  // Reference model: a queue of pending samples, a slot counter and the
  // value the hold mode repeats.
  int m_q[$];
  int m_L;
  int m_S;
  int m_phase;
  int m_held;
  int m_uf;
  int exp_out;
  int exp_strobe;

  function automatic int sat(input int x, input int s);
    int v;
    v = x * (1 << s);
    if (v > 15) return 15;
    if (v < -16) return -16;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic use_dut(input int s, input int l, input int shift);
    sel = s;
    m_L = l;
    m_S = shift;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_held  = 0;
    m_uf    = 0;
  endtask

  task automatic model_edge();
    int  v;
    bit  can_push;
    can_push = (m_q.size() != FD);
    if (m_phase == 0) begin
      exp_strobe = 1;
      if (m_q.size() > 0) begin
        v       = sat(m_q.pop_front(), m_S);
        exp_out = v;
        m_held  = v;
        if (clr) m_uf = 0;
      end else begin
        exp_out = 0;
        m_held  = 0;
        m_uf    = 1;
      end
    end else begin
      exp_strobe = 0;
      exp_out    = hold_mode ? m_held : 0;
      if (clr) m_uf = 0;
    end
    if (in_valid && can_push) begin
      v = 32'(in_data);
      m_q.push_back(v);
    end
    m_phase = (m_phase + 1) % m_L;
  endtask

  // Called one time unit after an edge; inputs are already set.
  task automatic cycle();
    check("in_ready", 32'(obs_ready), 32'(m_q.size() != FD));
    model_edge();
    @(posedge clk);
    #1;
    check("out", 32'(obs_out), exp_out);
    check("out_strobe", 32'(obs_strobe), exp_strobe);
    check("underflow", 32'(obs_uf), m_uf);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out", 32'(obs_out), 0);
    check("rst_strobe", 32'(obs_strobe), 0);
    check("rst_in_ready", 32'(obs_ready), 1);
    check("rst_underflow", 32'(obs_uf), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = W'(v);
    cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    hold_mode   = 1'b0;
    clr         = 1'b0;
    use_dut(0, 4, 0);
    model_reset();

    // 1: zero-stuffing of 3, -2, 7 then an empty slot
    do_reset();
    push(3); push(-2); push(7);
    in_valid = 1'b0;
    repeat (9) cycle();
    clr = 1'b1; cycle(); clr = 1'b0;
    repeat (8) cycle();

    // 2: same stimulus in hold mode
    hold_mode = 1'b1;
    do_reset();
    push(3); push(-2); push(7);
    in_valid = 1'b0;
    repeat (9) cycle();
    clr = 1'b1; cycle(); clr = 1'b0;
    repeat (8) cycle();
    hold_mode = 1'b0;

    // 3: gain shift 1 with saturation at both ends
    use_dut(1, 4, 1);
    do_reset();
    push(3); push(9); push(-9); push(-8);
    in_valid = 1'b0;
    repeat (18) cycle();

    // 4: continuous in_valid, backpressure and pointer wrap
    use_dut(0, 4, 0);
    do_reset();
    repeat (48) begin
      in_data = W'($urandom);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (20) cycle();

    // 5: L=1 streaming, underflow cleared once primed
    use_dut(2, 1, 0);
    do_reset();
    push(int'($urandom_range(0, 15)));
    clr = 1'b1;
    push(int'($urandom_range(0, 15)));
    clr = 1'b0;
    repeat (30) push(int'($urandom_range(0, 31)) - 16);
    in_valid = 1'b0;
    repeat (4) cycle();

    // 6: reset with samples buffered, then clear racing a new underflow
    use_dut(0, 4, 0);
    hold_mode = 1'b1;
    do_reset();
    push(5); push(-3); push(6);
    in_valid = 1'b0;
    repeat (3) cycle();
    do_reset();
    repeat (4) cycle();
    clr = 1'b1;
    cycle();
    check("uf_set_wins", 32'(obs_uf), 1);
    cycle();
    clr = 1'b0;
    check("uf_cleared", 32'(obs_uf), 0);
    repeat (12) cycle();
    hold_mode = 1'b0;

    // Random traffic on each configuration
    for (int d = 0; d < 3; d++) begin
      if (d == 0) use_dut(0, 4, 0);
      else if (d == 1) use_dut(1, 4, 1);
      else use_dut(2, 1, 0);
      do_reset();
      repeat (150) begin
        in_data   = W'($urandom);
        in_valid  = ($urandom_range(0, 3) != 0);
        hold_mode = $urandom_range(0, 1) != 0;
        clr       = ($urandom_range(0, 7) == 0);
        cycle();
      end
      in_valid = 1'b0;
      clr      = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
